// File: rtl/parity_bit_generator_if.sv
// Data/parity bundle between a parity source and the generator.
// master drives data bits and in_valid; slave returns parity, codeword and ones count.
interface parity_bit_generator_if;
   logic       a;
   logic       b;
   logic       c;
   logic       d;
   logic       in_valid;
   logic       p;
   logic [4:0] codeword;
   logic [2:0] ones_count;
   logic       out_valid;

   modport master (
      output a, b, c, d, in_valid,
      input  p, codeword, ones_count, out_valid
   );

   modport slave (
      input  a, b, c, d, in_valid,
      output p, codeword, ones_count, out_valid
   );
endinterface

// File: rtl/parity_bit_generator.sv
// 4-bit parity generator producing parity bit, 5-bit codeword and ones count.
// Latency 1 cycle when REGISTERED=1 (0 otherwise); never stalls, no back-pressure.
module parity_bit_generator #(
   parameter bit ODD_PARITY = 1'b0,
   parameter bit REGISTERED = 1'b1
) (
   input  logic                         clk,
   input  logic                         rst,
   parity_bit_generator_if.slave        bus
);

   logic [3:0] w_data;
   logic       w_p;
   logic [4:0] w_codeword;
   logic [2:0] w_ones;

   assign w_data     = {bus.a, bus.b, bus.c, bus.d};
   assign w_p        = (^w_data) ^ ODD_PARITY;
   assign w_codeword = {w_data, w_p};
   assign w_ones     = {2'b00, bus.a} + {2'b00, bus.b} + {2'b00, bus.c} + {2'b00, bus.d};

   generate
      if (REGISTERED) begin : g_reg
         logic       r_p;
         logic [4:0] r_codeword;
         logic [2:0] r_ones;
         logic       r_valid;

         // Reset p to ODD_PARITY so the all-zero codeword stays self-consistent.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_p        <= ODD_PARITY;
               r_codeword <= {4'b0000, ODD_PARITY};
               r_ones     <= 3'd0;
               r_valid    <= 1'b0;
            end else begin
               r_p        <= w_p;
               r_codeword <= w_codeword;
               r_ones     <= w_ones;
               r_valid    <= bus.in_valid;
            end
         end

         assign bus.p          = r_p;
         assign bus.codeword   = r_codeword;
         assign bus.ones_count = r_ones;
         assign bus.out_valid  = r_valid;
      end else begin : g_comb
         logic w_unused_clk_rst;
         assign w_unused_clk_rst = clk | rst;

         assign bus.p          = w_p;
         assign bus.codeword   = w_codeword;
         assign bus.ones_count = w_ones;
         assign bus.out_valid  = bus.in_valid;
      end
   endgenerate

endmodule

// File: tb/tb_parity_bit_generator.sv
// Checks even/odd registered and combinational generators against a counting model.
module tb_parity_bit_generator;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;

   parity_bit_generator_if if_even ();
   parity_bit_generator_if if_odd  ();
   parity_bit_generator_if if_comb ();

   parity_bit_generator #(.ODD_PARITY(1'b0), .REGISTERED(1'b1)) u_even (.clk(clk), .rst(rst), .bus(if_even));
   parity_bit_generator #(.ODD_PARITY(1'b1), .REGISTERED(1'b1)) u_odd  (.clk(clk), .rst(rst), .bus(if_odd));
   parity_bit_generator #(.ODD_PARITY(1'b0), .REGISTERED(1'b0)) u_comb (.clk(clk), .rst(rst), .bus(if_comb));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic int count_ones(input logic [3:0] v);
      int n = 0;
      for (int i = 0; i < 4; i++) if (v[i]) n++;
      return n;
   endfunction

   // Reference: parity bit makes the total ones count of the 5-bit word match the mode.
   task automatic check_out(input string tag, input bit odd, input logic [3:0] v, input logic vld,
                            input logic p, input logic [4:0] cw, input logic [2:0] oc, input logic ov);
      int  n;
      logic ep;
      n  = count_ones(v);
      ep = ((n % 2) == 1) ? ~odd : odd;
      check({tag, ".p"},  32'(p),  32'(ep));
      check({tag, ".cw"}, 32'(cw), 32'(v) * 2 + 32'(ep));
      check({tag, ".oc"}, 32'(oc), 32'(n));
      check({tag, ".ov"}, 32'(ov), 32'(vld));
      if (ov) check({tag, ".inv"}, 32'(count_ones(cw[4:1]) + int'(cw[0])) % 2, 32'(odd));
   endtask

   task automatic check_reset(input string tag);
      check({tag, ".even.p"},  32'(if_even.p), 0);
      check({tag, ".even.cw"}, 32'(if_even.codeword), 0);
      check({tag, ".even.oc"}, 32'(if_even.ones_count), 0);
      check({tag, ".even.ov"}, 32'(if_even.out_valid), 0);
      check({tag, ".odd.p"},   32'(if_odd.p), 1);
      check({tag, ".odd.cw"},  32'(if_odd.codeword), 1);
      check({tag, ".odd.ov"},  32'(if_odd.out_valid), 0);
   endtask

   task automatic drive(input logic [3:0] v, input logic vld);
      {if_even.a, if_even.b, if_even.c, if_even.d} = v;
      {if_odd.a,  if_odd.b,  if_odd.c,  if_odd.d}  = v;
      {if_comb.a, if_comb.b, if_comb.c, if_comb.d} = v;
      if_even.in_valid = vld;
      if_odd.in_valid  = vld;
      if_comb.in_valid = vld;
   endtask

   // Drive one input, check combinational path at once, registered paths after the edge.
   task automatic step(input string tag, input logic [3:0] v, input logic vld);
      drive(v, vld);
      #1;
      check_out({tag, ".comb"}, 1'b0, v, vld, if_comb.p, if_comb.codeword, if_comb.ones_count, if_comb.out_valid);
      @(posedge clk);
      #1;
      check_out({tag, ".even"}, 1'b0, v, vld, if_even.p, if_even.codeword, if_even.ones_count, if_even.out_valid);
      check_out({tag, ".odd"},  1'b1, v, vld, if_odd.p,  if_odd.codeword,  if_odd.ones_count,  if_odd.out_valid);
   endtask

   int sweep_p  [10] = '{0, 1, 1, 0, 1, 0, 0, 1, 1, 0};
   int sweep_oc [10] = '{0, 1, 1, 2, 1, 2, 2, 3, 1, 2};

   initial begin
      logic [3:0] rv;
      n_checks = 0;
      n_errors = 0;
      rst = 1'b0;
      drive(4'h0, 1'b0);

      // Asynchronous reset between edges.
      @(posedge clk);
      #3 rst = 1'b1;
      #1 check_reset("rst_async");
      @(posedge clk);
      #1 rst = 1'b0;

      // Even-parity sweep against the fixed table.
      for (int i = 0; i < 10; i++) begin
         step("sweep", 4'(i), 1'b1);
         check("sweep.tab_p",  32'(if_even.p), 32'(sweep_p[i]));
         check("sweep.tab_oc", 32'(if_even.ones_count), 32'(sweep_oc[i]));
      end

      for (int i = 0; i < 16; i++) step("exh", 4'(i), 1'b1);
      check("exh.1111_oc", 32'(if_even.ones_count), 4);
      check("exh.1111_p",  32'(if_even.p), 0);
      check("exh.1111_odd_p", 32'(if_odd.p), 1);

      step("odd0", 4'b0000, 1'b1);
      check("odd.0000_p", 32'(if_odd.p), 1);
      step("odd7", 4'b0111, 1'b1);
      check("odd.0111_p", 32'(if_odd.p), 0);

      for (int i = 0; i < 40; i++) begin
         rv = 4'($urandom_range(0, 15));
         step("rand", rv, 1'($urandom_range(0, 1)));
      end

      // Mid-stream reset.
      step("mid1", 4'b0001, 1'b1);
      step("mid3", 4'b0011, 1'b1);
      drive(4'b0111, 1'b1);
      rst = 1'b1;
      #1 check_reset("rst_mid");
      @(posedge clk);
      #1 check_reset("rst_hold");
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("post.p",  32'(if_even.p), 1);
      check("post.oc", 32'(if_even.ones_count), 3);
      check("post.ov", 32'(if_even.out_valid), 1);

      // Combinational mode follows inputs between edges.
      @(posedge clk);
      #2 drive(4'b1010, 1'b1);
      #1 check("comb.1010_p", 32'(if_comb.p), 0);
      drive(4'b1011, 1'b0);
      #1 check("comb.1011_p", 32'(if_comb.p), 1);
      check("comb.ov", 32'(if_comb.out_valid), 0);
      check("comb.oc", 32'(if_comb.ones_count), 3);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
